// File: rtl/addv_accumulator.sv
// rtl/addv_accumulator.sv - signed group accumulator around a prefix adder (AddV)
// Optional saturation of the running sum: define ADDV_ACCUMULATOR_SAT_EN.

package lau_pkg;
  typedef enum logic {SLOW = 1'b0, FAST = 1'b1} speed_e;
endpackage

// Two's complement adder with carry-in; V flags signed overflow of this add.
module addv #(
  parameter int unsigned     width = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             ci,
  output logic [width-1:0] s,
  output logic             v
);
  localparam int unsigned LV = $clog2(width);

  logic [width-1:0] g0, p0, cf;
  logic [width:0]   c;

  assign p0 = a ^ b;
  // Carry-in is folded into the bit-0 generate so the prefix tree needs no extra column.
  assign g0 = (a & b) | {{(width-1){1'b0}}, p0[0] & ci};

  if (speed == lau_pkg::FAST) begin : g_fast
    always_comb begin
      logic [width-1:0] gg, pp, gn, pn;
      gg = g0;
      pp = p0;
      for (int k = 0; k < LV; k++) begin
        gn = gg;
        pn = pp;
        for (int i = 0; i < width; i++) begin
          if (i >= (1 << k)) begin
            gn[i] = gg[i] | (pp[i] & gg[i-(1<<k)]);
            pn[i] = pp[i] & pp[i-(1<<k)];
          end
        end
        gg = gn;
        pp = pn;
      end
      cf = gg;
    end
  end else begin : g_ripple
    always_comb begin
      logic [width-1:0] r;
      r    = '0;
      r[0] = g0[0];
      for (int i = 1; i < width; i++) r[i] = g0[i] | (p0[i] & r[i-1]);
      cf = r;
    end
  end

  assign c = {cf, ci};
  assign s = p0 ^ c[width-1:0];
  assign v = c[width] ^ c[width-1];
endmodule

module addv_accumulator #(
  parameter int unsigned     width = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST,
  parameter int unsigned     len   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] in_data_i,
  input  logic             in_ci_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] out_sum_o,
  output logic             out_ovf_o
);
  localparam int unsigned CW = $clog2(len + 1);

  typedef enum logic {ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] acc_q, sum, acc_nxt;
  logic             ovf_q, v;
  logic [CW-1:0]    cnt_q;
  logic             last, in_fire, out_fire;

  addv #(.width(width), .speed(speed)) u_addv (
    .a  (acc_q),
    .b  (in_data_i),
    .ci (in_ci_i),
    .s  (sum),
    .v  (v)
  );

`ifdef ADDV_ACCUMULATOR_SAT_EN
  // On overflow the operand sign tells which rail was crossed.
  assign acc_nxt = !v ? sum :
                   in_data_i[width-1] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
`else
  assign acc_nxt = sum;
`endif

  assign last     = (cnt_q == CW'(len - 1));
  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      ACC: begin
        in_ready_o = ~clear_i;
        if (in_valid_i && !clear_i && last) state_d = DONE;
      end
      DONE: begin
        out_valid_o = ~clear_i;
        if (out_ready_i && !clear_i) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
    if (clear_i) state_d = ACC;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ACC;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (in_fire) begin
      acc_q <= acc_nxt;
      ovf_q <= ovf_q | v;
      cnt_q <= last ? '0 : cnt_q + CW'(1);
    end else if (out_fire) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end
  end

  assign out_sum_o = acc_q;
  assign out_ovf_o = ovf_q;
endmodule

// File: tb/tb_addv_accumulator.sv
// tb/tb_addv_accumulator.sv - randomized and directed bench for addv_accumulator
module tb_addv_accumulator;
  localparam int W   = 8;
  localparam int LEN = 4;

  logic         clk = 0, rst_n = 0, clear = 0, in_valid = 0, in_ci = 0, out_ready = 1;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, out_ovf;
  logic [W-1:0] out_sum;

  int n_pass = 0, n_total = 0;

  addv_accumulator #(.width(W), .speed(lau_pkg::FAST), .len(LEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_ci_i(in_ci),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sum_o(out_sum), .out_ovf_o(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: integer group sum, a pending-result flag, and a beat count.
  int  m_acc;
  bit  m_ovf, m_pend;
  int  m_cnt;

  function automatic void m_step(input logic [W-1:0] d, input logic c);
    int r;
    r = m_acc + int'($signed(d)) + int'(c);
    if (r > 127 || r < -128) begin
      m_ovf = 1;
`ifdef ADDV_ACCUMULATOR_SAT_EN
      r = d[W-1] ? -128 : 127;
`endif
    end
    if (r > 127) r -= 256;
    if (r < -128) r += 256;
    m_acc = r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_ovf = 0; m_pend = 0; m_cnt = 0;
    end else if (clear) begin
      m_acc = 0; m_ovf = 0; m_pend = 0; m_cnt = 0;
    end else if (m_pend) begin
      if (out_ready) begin
        m_pend = 0; m_acc = 0; m_ovf = 0;
      end
    end else if (in_valid) begin
      m_step(in_data, in_ci);
      m_cnt++;
      if (m_cnt == LEN) begin
        m_cnt  = 0;
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_ovf", out_ovf, 0);
    end else begin
      chk("in_ready", in_ready, !clear && !m_pend);
      chk("out_valid", out_valid, m_pend && !clear);
      if (m_pend && !clear) begin
        chk("out_sum", out_sum, m_acc[W-1:0]);
        chk("out_ovf", out_ovf, m_ovf);
      end
    end
  end

  task automatic feed_op(input logic [W-1:0] d, input logic c);
    logic taken;
    int   n;
    taken = 0;
    n = 0;
    in_valid = 1; in_data = d; in_ci = c;
    while (!taken && n < 30) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!taken) chk("accept_timeout", 0, 1);
    in_valid = 0; in_data = W'($urandom); in_ci = 1'($urandom);
  endtask

  task automatic run_group(input string nm, input logic [3:0][W-1:0] d, input logic [3:0] c,
                           input int hold, input logic [W-1:0] es, input logic eo);
    out_ready = (hold == 0);
    for (int i = 0; i < LEN; i++) feed_op(d[i], c[i]);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_sum"}, out_sum, es);
    chk({nm, "_ovf"}, out_ovf, eo);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_ready"}, in_ready, 0);
      chk({nm, "_hold_sum"}, out_sum, es);
      chk({nm, "_hold_ovf"}, out_ovf, eo);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk({nm, "_popped"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    run_group("basic", {8'd4, 8'd3, 8'd2, 8'd1}, 4'b0000, 0, 8'h0A, 0);
    run_group("carry", {8'd1, 8'd1, 8'd1, 8'd1}, 4'b1111, 0, 8'h08, 0);
`ifdef ADDV_ACCUMULATOR_SAT_EN
    run_group("posovf", {8'd0, 8'd0, 8'd50, 8'd100}, 4'b0000, 0, 8'h7F, 1);
    run_group("negovf", {8'd0, 8'd0, 8'hFF, 8'h80}, 4'b0000, 0, 8'h80, 1);
`else
    run_group("posovf", {8'd0, 8'd0, 8'd50, 8'd100}, 4'b0000, 0, 8'h96, 1);
    run_group("negovf", {8'd0, 8'd0, 8'hFF, 8'h80}, 4'b0000, 0, 8'h7F, 1);
`endif
    run_group("bp", {8'd40, 8'd30, 8'd20, 8'd10}, 4'b0000, 5, 8'h64, 0);
    run_group("after_bp", {8'd2, 8'd2, 8'd2, 8'd2}, 4'b0000, 0, 8'h08, 0);

    feed_op(8'd7, 1);
    feed_op(8'd9, 0);
    clear = 1;
    @(posedge clk); #1 clear = 0;
    run_group("after_clear", {8'd5, 8'd5, 8'd5, 8'd5}, 4'b0000, 0, 8'h14, 0);

    out_ready = 0;
    for (int i = 0; i < LEN; i++) feed_op(8'd3, 0);
    chk("drop_valid_before", out_valid, 1);
    clear = 1; out_ready = 1;
    #1 chk("drop_valid_in_clear", out_valid, 0);
    @(posedge clk); #1 clear = 0;
    chk("drop_valid_after", out_valid, 0);
    chk("drop_sum_after", out_sum, 0);

    out_ready = 0;
    for (int i = 0; i < LEN; i++) feed_op(8'd6, 0);
    chk("rst_done_valid_before", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_done_valid", out_valid, 0);
    chk("rst_done_sum", out_sum, 0);
    @(posedge clk); #1 rst_n = 1;
    out_ready = 1;
    run_group("after_rst", {8'd4, 8'd3, 8'd2, 8'd1}, 4'b0001, 0, 8'h0B, 0);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = W'($urandom);
      in_ci     = 1'($urandom);
      clear     = ($urandom % 40) == 0;
      out_ready = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    in_valid = 0; clear = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
